// File: rtl/door_plant_sim_pkg.sv
// Shared types and constants for the gate plant model: state encoding,
// direction values and the state-classification helper.
package door_pkg;

  localparam int POS_W = 4;

  localparam logic SENTIDO_ABRIR  = 1'b0;
  localparam logic SENTIDO_FECHAR = 1'b1;

  typedef enum logic [2:0] {
    FECHADO  = 3'b000,
    ABRINDO  = 3'b001,
    ABERTO   = 3'b010,
    FECHANDO = 3'b011,
    PARADO   = 3'b100
  } estado_t;

  // Moving states take priority; at rest the position alone decides.
  function automatic estado_t estado_de(input logic [POS_W-1:0] pos,
                                        input logic [POS_W-1:0] pos_max,
                                        input logic             motor,
                                        input logic             sentido);
    estado_t e;
    if (motor && (sentido == SENTIDO_ABRIR) && (pos < pos_max)) begin
      e = ABRINDO;
    end else if (motor && (sentido == SENTIDO_FECHAR) && (pos != {POS_W{1'b0}})) begin
      e = FECHANDO;
    end else if (pos == {POS_W{1'b0}}) begin
      e = FECHADO;
    end else if (pos == pos_max) begin
      e = ABERTO;
    end else begin
      e = PARADO;
    end
    return e;
  endfunction

endpackage

// File: rtl/door_plant_sim_if.sv
// Signal bundle between the gate controller (master) and the plant model (slave).
interface door_plant_sim_if;
  import door_pkg::*;

  logic             botao_raw;
  logic             motor;
  logic             sentido;
  logic             botao;
  logic             botao_pulso;
  logic             aberto;
  logic             fechado;
  logic [POS_W-1:0] posicao;
  estado_t          estado;
  logic             falha;

  modport master (
    output botao_raw, motor, sentido,
    input  botao, botao_pulso, aberto, fechado, posicao, estado, falha
  );

  modport slave (
    input  botao_raw, motor, sentido,
    output botao, botao_pulso, aberto, fechado, posicao, estado, falha
  );

endinterface

// File: rtl/door_plant_sim_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and
// rising-edge pulse. Reusable for any board key.
module debounce_botao #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_nivel,
  output logic o_pulso
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_nivel;
  logic             r_pulso;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_fim;

  assign w_diff = r_sync2 ^ r_nivel;
  assign w_fim  = w_diff && (r_cnt == CNT_LAST);

  // Any sample equal to the clean level restarts the stability window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_nivel <= 1'b0;
      r_pulso <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_diff || w_fim) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_fim) begin
        r_nivel <= r_sync2;
      end else begin
        r_nivel <= r_nivel;
      end
      r_pulso <= w_fim && r_sync2;
    end
  end

  assign o_nivel = r_nivel;
  assign o_pulso = r_pulso;

endmodule

// File: rtl/door_plant_sim.sv
// Gate plant model: debounced button plus a stepped position model driven by
// the controller's motor/sentido, with end stops, stall fault and state.
module door_plant_sim
  import door_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STEP_CYCLES     = 25_000_000,
  parameter int TRAVEL_STEPS    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  door_plant_sim_if.slave  bus
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(TRAVEL_STEPS);

  logic [STEP_W-1:0] r_timer, w_timer_nxt;
  logic [STEP_W-1:0] r_stall, w_stall_nxt;
  logic [POS_W-1:0]  r_posicao, w_pos_nxt;
  logic              r_sentido_prev, r_aberto, r_fechado, r_falha, w_falha_nxt;
  estado_t           r_estado, w_estado_nxt;
  logic              w_no_fim, w_bloqueado, w_reverte;

  debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (bus.botao_raw),
    .o_nivel (bus.botao),
    .o_pulso (bus.botao_pulso)
  );

  assign w_no_fim    = (bus.sentido == SENTIDO_ABRIR) ? (r_posicao == POS_MAX)
                                                      : (r_posicao == '0);
  assign w_bloqueado = bus.motor && w_no_fim;
  assign w_reverte   = bus.sentido != r_sentido_prev;

  // Step timer; never stepping while at the end stop keeps posicao saturated.
  always_comb begin
    w_timer_nxt = r_timer;
    w_pos_nxt   = r_posicao;
    if (!bus.motor || w_reverte || w_no_fim) begin
      w_timer_nxt = '0;
    end else if (r_timer == STEP_LAST) begin
      w_timer_nxt = '0;
      if (bus.sentido == SENTIDO_ABRIR) begin
        w_pos_nxt = r_posicao + POS_W'(1);
      end else begin
        w_pos_nxt = r_posicao - POS_W'(1);
      end
    end else begin
      w_timer_nxt = r_timer + STEP_W'(1);
    end
  end

  // Stall detection: driving into the stop already reached.
  always_comb begin
    w_stall_nxt = '0;
    w_falha_nxt = r_falha;
    if (w_bloqueado) begin
      if (r_stall == STEP_LAST) begin
        w_falha_nxt = 1'b1;
      end else begin
        w_stall_nxt = r_stall + STEP_W'(1);
      end
    end else begin
      w_stall_nxt = '0;
    end
  end

  // Next plant state from the post-edge position and current command.
  always_comb begin
    w_estado_nxt = FECHADO;
    case (r_estado)
      FECHADO, ABRINDO, ABERTO, FECHANDO, PARADO:
        w_estado_nxt = estado_de(w_pos_nxt, POS_MAX, bus.motor, bus.sentido);
      default:
        w_estado_nxt = FECHADO;
    endcase
  end

  // Plant state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado <= FECHADO;
    end else begin
      r_estado <= w_estado_nxt;
    end
  end

  // Position, end stops, timers and fault; end stops follow posicao same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timer        <= '0;
      r_stall        <= '0;
      r_posicao      <= '0;
      r_sentido_prev <= 1'b0;
      r_aberto       <= 1'b0;
      r_fechado      <= 1'b1;
      r_falha        <= 1'b0;
    end else begin
      r_timer        <= w_timer_nxt;
      r_stall        <= w_stall_nxt;
      r_posicao      <= w_pos_nxt;
      r_sentido_prev <= bus.sentido;
      r_aberto       <= (w_pos_nxt == POS_MAX);
      r_fechado      <= (w_pos_nxt == '0);
      r_falha        <= w_falha_nxt;
    end
  end

  assign bus.posicao = r_posicao;
  assign bus.aberto  = r_aberto;
  assign bus.fechado = r_fechado;
  assign bus.estado  = r_estado;
  assign bus.falha   = r_falha;

endmodule

// File: tb/tb_door_plant_sim.sv
// Bench for door_plant_sim: directed scenarios then random stimulus, all
// outputs compared every cycle against a behavioural gate model.
module tb_door_plant_sim;

  localparam int DEB = 4;
  localparam int STP = 3;
  localparam int TRV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  door_plant_sim_if bus();

  door_plant_sim #(
    .DEBOUNCE_CYCLES (DEB),
    .STEP_CYCLES     (STP),
    .TRAVEL_STEPS    (TRV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_edge   = 0;
  int n_pulse  = 0;

  // Behavioural model state
  bit raw_hist[$];
  bit m_botao, m_pulso, m_falha, m_sen_prev;
  int m_pos, m_drive, m_stall, m_estado;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, n_edge);
    end
  endtask

  function automatic int ref_estado(input int p, input bit mot, input bit sen);
    if (mot && !sen && p < TRV) return 1;
    if (mot && sen && p > 0)    return 3;
    if (p == 0)                 return 0;
    if (p == TRV)               return 2;
    return 4;
  endfunction

  task automatic model_reset();
    raw_hist.delete();
    for (int i = 0; i < DEB + 2; i++) raw_hist.push_back(1'b0);
    m_botao = 0; m_pulso = 0; m_falha = 0; m_sen_prev = 0;
    m_pos = 0; m_drive = 0; m_stall = 0; m_estado = 0;
  endtask

  // One clock edge of the reference: inputs as held across this edge.
  task automatic model_edge();
    bit mot, sen, blk, stable;
    int p;
    if (!rst_n) begin
      model_reset();
      return;
    end
    mot = bus.motor;
    sen = bus.sentido;
    // Button: the level seen 2..DEB+1 edges ago must all differ from botao.
    raw_hist.push_front(bus.botao_raw);
    if (raw_hist.size() > DEB + 2) void'(raw_hist.pop_back());
    stable = 1;
    for (int d = 2; d <= DEB + 1; d++) if (raw_hist[d] == m_botao) stable = 0;
    m_pulso = stable && !m_botao;
    if (stable) m_botao = !m_botao;
    // Motion: STP consecutive drive edges move the gate one position.
    blk = (!sen && m_pos == TRV) || (sen && m_pos == 0);
    p = m_pos;
    if (!mot || sen != m_sen_prev || blk) begin
      m_drive = 0;
    end else begin
      m_drive++;
      if (m_drive == STP) begin
        m_drive = 0;
        p = sen ? p - 1 : p + 1;
      end
    end
    if (mot && blk) begin
      m_stall++;
      if (m_stall == STP) begin
        m_falha = 1;
        m_stall = 0;
      end
    end else begin
      m_stall = 0;
    end
    m_sen_prev = sen;
    m_pos = p;
    m_estado = ref_estado(p, mot, sen);
  endtask

  task automatic tick();
    @(posedge clk);
    n_edge++;
    model_edge();
    #1;
    if (bus.botao_pulso === 1'b1) n_pulse++;
    chk("botao",   bus.botao,       m_botao);
    chk("pulso",   bus.botao_pulso, m_pulso);
    chk("posicao", bus.posicao,     m_pos);
    chk("fechado", bus.fechado,     (m_pos == 0));
    chk("aberto",  bus.aberto,      (m_pos == TRV));
    chk("estado",  bus.estado,      m_estado);
    chk("falha",   bus.falha,       m_falha);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int last_e, rise_e, hold;
    bus.botao_raw = 0;
    bus.motor     = 1;
    bus.sentido   = 0;
    model_reset();

    // Reset with motor active
    rst_n = 0;
    tick();
    chk("rst_posicao", bus.posicao, 0);
    chk("rst_fechado", bus.fechado, 1);
    chk("rst_estado",  bus.estado,  0);
    chk("rst_botao",   bus.botao,   0);
    rst_n = 1;
    bus.motor = 0;
    ticks(2);

    // Bounce then settle high
    n_pulse = 0;
    last_e  = 0;
    for (int i = 0; i < 10; i++) begin
      bus.botao_raw = ((i / 2) % 2 == 0);
      if (i == 8) last_e = n_edge + 1;
      tick();
      chk("bounce_quiet", bus.botao, 0);
    end
    rise_e = -1;
    for (int i = 0; i < 20 && rise_e < 0; i++) begin
      tick();
      if (bus.botao === 1'b1) rise_e = n_edge;
    end
    chk("bounce_lat", rise_e - last_e + 1, 2 + DEB);
    ticks(4);
    chk("bounce_pulses", n_pulse, 1);

    // Full open from closed
    bus.motor = 1; bus.sentido = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k % 3 == 0) chk("open_pos", bus.posicao, k / 3);
      if (k == 1)  chk("open_estado", bus.estado, 1);
      if (k == 3)  chk("open_fechado", bus.fechado, 0);
      if (k == 11) chk("open_aberto_early", bus.aberto, 0);
    end
    chk("open_aberto", bus.aberto, 1);
    chk("open_estado_end", bus.estado, 2);
    bus.motor = 0;
    tick();

    // Stall into the open stop
    bus.motor = 1; bus.sentido = 0;
    ticks(3);
    chk("stall_falha", bus.falha, 1);
    bus.motor = 0;
    ticks(3);
    chk("stall_sticky", bus.falha, 1);
    chk("stall_pos", bus.posicao, TRV);
    rst_n = 0; tick(); rst_n = 1;
    chk("stall_clr", bus.falha, 0);
    chk("stall_clr_pos", bus.posicao, 0);

    // Reversal one cycle into a step
    bus.motor = 1; bus.sentido = 0;
    ticks(6);
    chk("rev_pos2", bus.posicao, 2);
    tick();
    bus.sentido = 1;
    tick();
    ticks(2);
    chk("rev_hold", bus.posicao, 2);
    tick();
    chk("rev_pos1", bus.posicao, 1);
    chk("rev_estado", bus.estado, 3);
    bus.motor = 0; bus.sentido = 0;
    tick();

    // Reset mid-travel
    rst_n = 0; tick(); rst_n = 1;
    bus.motor = 1; bus.sentido = 0;
    ticks(9);
    chk("mid_pos3", bus.posicao, 3);
    rst_n = 0;
    tick();
    chk("mid_rst_pos", bus.posicao, 0);
    chk("mid_rst_fechado", bus.fechado, 1);
    rst_n = 1;
    ticks(2);
    chk("mid_restart_hold", bus.posicao, 0);
    tick();
    chk("mid_restart_step", bus.posicao, 1);

    // Random phase
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        bus.botao_raw = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 11) == 0) bus.motor = ~bus.motor;
      if ($urandom_range(0, 15) == 0) bus.sentido = ~bus.sentido;
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
